// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with forwarding, load-use and multi-cycle MDU interlocks
module hazard_unit_mc #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter bit MDU_EN            = 1'b1,
    parameter int PERF_W            = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              result_src_e_0,
    input  logic              pc_src_e,
    input  logic              mdu_start_e,
    input  logic              mdu_done,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output logic [1:0]        forward_operand_a_e,
    output logic [1:0]        forward_operand_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       lw_hz;
    logic       mdu_start;

    assign lw_hz     = result_src_e_0 && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
    assign mdu_start = MDU_EN && mdu_start_e;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if ((rs != '0) && regwrite_m && (rs == rd_m))
            return 2'b10;
        else if ((rs != '0) && regwrite_w && (rs == rd_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forward_operand_a_e = 2'b00;
        forward_operand_b_e = 2'b00;
        if (!reset) begin
            forward_operand_a_e = fwd_sel(rs1_e);
            forward_operand_b_e = fwd_sel(rs2_e);
        end
    end

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (!reset) begin
            case (state)
                RUN: begin
                    // A taken branch squashes the D instruction, so its load-use hazard is moot.
                    if (pc_src_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (mdu_start && !mdu_done) begin
                        stall_f    = 1'b1;
                        stall_d    = 1'b1;
                        stall_e    = 1'b1;
                        flush_m    = 1'b1;
                        state_next = MDU_WAIT;
                    end else if (mdu_start) begin
                        state_next = RUN;
                    end else if (lw_hz) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            wait_cnt_next = LOAD_RELOAD;
                            state_next    = LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    stall_f       = 1'b1;
                    stall_d       = 1'b1;
                    flush_e       = 1'b1;
                    wait_cnt_next = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1)
                        state_next = RUN;
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (stall_f && (stall_cycles != '1))
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised successor to the 5-stage hazard unit, with multi-cycle stall support. Provides M/W operand forwarding for the E stage and load-use interlock with a configurable stall length. Adds a multi-cycle MDU (mul/div) interlock that holds the E stage until the MDU signals done. Includes a saturating stall-cycle performance counter. Sits beside the pipeline registers and drives their stall/flush enables.

Parameters:
REG_AW, 5, register-address width.
LOAD_STALL_CYCLES, 1, cycles of stall per load-use hazard (legal 1..15).
MDU_EN, 1, 1 enables the MDU interlock; 0 ties the MDU logic off (mdu_start_e ignored).
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rs1_d  in  REG_AW  D-stage source 1
rs2_d  in  REG_AW  D-stage source 2
rs1_e  in  REG_AW  E-stage source 1
rs2_e  in  REG_AW  E-stage source 2
rd_e  in  REG_AW  E-stage destination
result_src_e_0  in  1  E-stage instruction is a load
pc_src_e  in  1  taken branch/jump resolved in E
mdu_start_e  in  1  E-stage instruction is a multi-cycle MDU op (valid in first E cycle)
mdu_done  in  1  MDU result ready this cycle
rd_m  in  REG_AW  M-stage destination
regwrite_m  in  1  M-stage writes register
rd_w  in  REG_AW  W-stage destination
regwrite_w  in  1  W-stage writes register
forward_operand_a_e  out  2  00 regfile, 10 from M, 01 from W
forward_operand_b_e  out  2  same encoding, operand b
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
stall_e  out  1  hold ID/EX register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register
flush_m  out  1  clear EX/MEM register (inject bubble)
stall_cycles  out  PERF_W  saturating count of cycles with stall_f=1

Behaviour:
- All stall/flush/forward outputs are combinational from state plus inputs (zero latency). Only the FSM, the wait counter and stall_cycles are registered.
- While reset=1: every stall/flush output is 0 and forwards are 00. On the clock edge with reset=1: state=RUN, wait counter=0, stall_cycles=0.
- Forwarding (operand a shown, b identical with rs2_e):
  - 10 if rs1_e==rd_m & regwrite_m & rs1_e!=0.
  - else 01 if rs1_e==rd_w & regwrite_w & rs1_e!=0.
  - else 00.
  - M has priority over W. Forwarding is active in every state.
- lw_hz = result_src_e_0 & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e). Unlike the previous generation, x0 never stalls.
- FSM states: RUN, LOAD_WAIT, MDU_WAIT.
- RUN:
  - pc_src_e=1 → flush_d=1, flush_e=1, no stall. This has priority over lw_hz because the D instruction is squashed. Stay in RUN.
  - else mdu_start_e & MDU_EN & !mdu_done → stall_f=stall_d=stall_e=1, flush_m=1; go to MDU_WAIT.
  - else mdu_start_e & mdu_done (single-cycle result) → no stall.
  - else lw_hz → stall_f=stall_d=1, flush_e=1.
    - If LOAD_STALL_CYCLES==1, stay in RUN.
    - Otherwise load counter with LOAD_STALL_CYCLES-1 and go to LOAD_WAIT.
- LOAD_WAIT: stall_f=stall_d=1, flush_e=1. Counter decrements each cycle; at counter==1 go to RUN. Total stall = exactly LOAD_STALL_CYCLES cycles.
- MDU_WAIT:
  - While !mdu_done: stall_f=stall_d=stall_e=1, flush_m=1.
  - On the cycle mdu_done=1: all stalls deasserted (the E instruction advances) and go to RUN.
- pc_src_e, lw_hz and mdu_start_e are ignored in LOAD_WAIT and MDU_WAIT. E holds a bubble or the MDU op in those states, so upstream guarantees none are asserted.
- flush_d, flush_e and stall_d are never simultaneously 1 with a conflicting stall_e/flush_e pair. In RUN, stall_e=1 implies flush_e=0.
- stall_cycles increments on every cycle with stall_f=1 and saturates at all-ones.
- Reset asserted mid-LOAD_WAIT or mid-MDU_WAIT aborts immediately: outputs drop to 0 in the same cycle, and the next state is RUN.

Test Plan:
- Forward priority: rs1_e=rs2_e=5, rd_m=5/regwrite_m=1, rd_w=5/regwrite_w=1 → a=b=10. Drop regwrite_m → 01. Set rs1_e=0 → a=00.
- Load-use, LOAD_STALL_CYCLES=3: result_src_e_0=1, rd_e=7, rs2_d=7 → stall_f/stall_d/flush_e high for exactly 3 cycles, then RUN; stall_cycles=3. Repeat with rd_e=0 → no stall.
- Branch vs load-use: lw_hz and pc_src_e both 1 → flush_d=flush_e=1, stall_f=0, state stays RUN.
- MDU: mdu_start_e=1, mdu_done after 5 cycles → stall_f/d/e and flush_m high for 5 cycles, all low on the done cycle. mdu_start_e with mdu_done same cycle → no stall. MDU_EN=0 → never stalls.
- Reset mid-operation: assert reset during the 2nd MDU_WAIT cycle → outputs 0 that cycle, stall_cycles=0 next cycle, state RUN.
- Counter saturation, PERF_W=4: 20 consecutive stall cycles → stall_cycles holds 15.
